// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the dual-port dmem between two requesters
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_wren,
   output logic [AW-1:0] mem_addr_a,
   output logic [AW-1:0] mem_addr_b,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_q_a,
   input  logic [DW-1:0] mem_q_b
);
   logic prio, both, clash, a_sel, b_use, a_act, psel0, psel1;
   logic [DW-1:0] hold0, hold1;
   // clash: only one of the two can be served; prio picks who gets port A
   always_comb begin
      both       = m0_req & m1_req;
      clash      = both & ((m0_we & m1_we) | ((m0_we ^ m1_we) & (m0_addr == m1_addr)));
      a_sel      = both ? (((m0_we ^ m1_we) & ~clash) ? m1_we : prio) : ~m0_req;
      b_use      = both & ~clash;
      m0_gnt     = m0_req & ~(clash & prio);
      m1_gnt     = m1_req & ~(clash & ~prio);
      a_act      = m0_gnt | m1_gnt;
      mem_addr_a = a_act ? (a_sel ? m1_addr : m0_addr) : '0;
      mem_wren   = a_act & (a_sel ? m1_we : m0_we);
      mem_wdata  = a_act ? (a_sel ? m1_wdata : m0_wdata) : '0;
      mem_addr_b = b_use ? (a_sel ? m0_addr : m1_addr) : '0;
      m0_rdata   = m0_rvalid ? (psel0 ? mem_q_b : mem_q_a) : hold0;
      m1_rdata   = m1_rvalid ? (psel1 ? mem_q_b : mem_q_a) : hold1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio      <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         psel0     <= 1'b0;
         psel1     <= 1'b0;
         hold0     <= '0;
         hold1     <= '0;
      end else begin
         prio      <= (m0_req & ~m0_gnt) ? 1'b0 : (m1_req & ~m1_gnt) ? 1'b1 : prio;
         m0_rvalid <= m0_gnt & ~m0_we;
         m1_rvalid <= m1_gnt & ~m1_we;
         psel0     <= b_use & a_sel;
         psel1     <= b_use & ~a_sel;
         hold0     <= m0_rdata;
         hold1     <= m1_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a rule-level model
module tb_dmem_arbiter;
   logic clk, rst_n;
   logic m0_req, m0_we, m0_gnt, m0_rvalid;
   logic m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic mem_wren;
   logic [31:0] mem_addr_a, mem_addr_b, mem_wdata, mem_q_a, mem_q_b;
   logic [31:0] dmem [0:65535];
   logic [31:0] shadow [0:65535];
   int checks = 0, errors = 0;
   int mprio;
   logic erv [2];
   logic [31:0] erd [2];
   logic last_g [2];

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_wren(mem_wren), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
      .mem_wdata(mem_wdata), .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [31:0] initv(input int a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // behavioural dmem: registered reads on both ports, write on port A
   always @(posedge clk) begin
      mem_q_a <= dmem[mem_addr_a[15:0]];
      mem_q_b <= dmem[mem_addr_b[15:0]];
      if (mem_wren) dmem[mem_addr_a[15:0]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mprio = 0;
      erv[0] = 0; erv[1] = 0;
      erd[0] = 0; erd[1] = 0;
   endtask

   // one cycle: drive, check against model, advance the model, step the clock
   task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      logic req [2];
      logic we [2];
      logic [31:0] ad [2];
      logic [31:0] wd [2];
      logic eg [2];
      logic ewren;
      logic [31:0] eaa, eab, ewd;
      int w, l, wr, rd;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      req[0] = r0; we[0] = w0; ad[0] = a0; wd[0] = d0;
      req[1] = r1; we[1] = w1; ad[1] = a1; wd[1] = d1;
      #3;
      chk("m0_rvalid", m0_rvalid, erv[0]);
      chk("m1_rvalid", m1_rvalid, erv[1]);
      chk("m0_rdata", m0_rdata, erd[0]);
      chk("m1_rdata", m1_rdata, erd[1]);
      eg[0] = 0; eg[1] = 0; ewren = 0; eaa = 0; eab = 0; ewd = 0;
      if (req[0] && req[1]) begin
         w = mprio; l = 1 - mprio;
         if (!we[0] && !we[1]) begin
            eg[0] = 1; eg[1] = 1; eaa = ad[w]; eab = ad[l];
         end else if (we[0] && we[1]) begin
            eg[w] = 1; eaa = ad[w]; ewren = 1; ewd = wd[w];
         end else begin
            wr = we[1] ? 1 : 0; rd = 1 - wr;
            if (ad[0] == ad[1]) begin
               eg[w] = 1; eaa = ad[w]; ewren = we[w]; ewd = we[w] ? wd[w] : 0;
            end else begin
               eg[0] = 1; eg[1] = 1; eaa = ad[wr]; eab = ad[rd]; ewren = 1; ewd = wd[wr];
            end
         end
      end else begin
         for (int i = 0; i < 2; i++)
            if (req[i]) begin
               eg[i] = 1; eaa = ad[i]; ewren = we[i]; ewd = we[i] ? wd[i] : 0;
            end
      end
      chk("m0_gnt", m0_gnt, eg[0]);
      chk("m1_gnt", m1_gnt, eg[1]);
      chk("mem_wren", mem_wren, ewren);
      chk("mem_addr_a", mem_addr_a, eaa);
      chk("mem_addr_b", mem_addr_b, eab);
      if (ewren || (!eg[0] && !eg[1])) chk("mem_wdata", mem_wdata, ewd);
      for (int i = 0; i < 2; i++) begin
         if (req[i] && !eg[i]) mprio = i;
         erv[i] = eg[i] && !we[i];
         if (erv[i]) erd[i] = shadow[ad[i][15:0]];
         last_g[i] = eg[i];
      end
      if (ewren) shadow[eaa[15:0]] = ewd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic hr [2];
      logic hw [2];
      logic [31:0] ha [2];
      logic [31:0] hd [2];
      logic [31:0] t5d;
      for (int i = 0; i < 65536; i++) begin
         dmem[i] = initv(i);
         shadow[i] = initv(i);
      end
      rst_n = 0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      #3;
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      chk("idle_wren", mem_wren, 0);
      chk("idle_addr_a", mem_addr_a, 0);
      // reset in the middle of a granted read drops the response
      m0_req = 1; m0_addr = 32'h05;
      #1;
      chk("t1_gnt", m0_gnt, 1);
      chk("t1_addr_a", mem_addr_a, 32'h05);
      rst_n = 0;
      @(posedge clk);
      #1;
      chk("t1_rvalid_in_rst", m0_rvalid, 0);
      m0_req = 0;
      rst_n = 1;
      model_reset();
      @(posedge clk);
      #1;
      chk("t1_rvalid_after", m0_rvalid, 0);
      chk("t1_rdata_after", m0_rdata, 0);
      // both read
      cyc(1, 0, 32'h00, 0, 1, 0, 32'h19, 0);
      chk("t2_m0_rvalid", m0_rvalid, 1);
      chk("t2_m0_rdata", m0_rdata, initv(32'h00));
      chk("t2_m1_rvalid", m1_rvalid, 1);
      chk("t2_m1_rdata", m1_rdata, initv(32'h19));
      // write on A, read on B, different addresses
      cyc(1, 1, 32'h05, 32'hDEADBEEF, 1, 0, 32'h232D, 0);
      chk("t3_m1_rdata", m1_rdata, initv(32'h232D));
      chk("t3_m0_rvalid", m0_rvalid, 0);
      // same-address read during write: reader waits one cycle then takes A
      cyc(1, 1, 32'h05, 32'hDEADBEEF, 1, 0, 32'h05, 0);
      chk("t4_c0_g1", last_g[1], 0);
      cyc(1, 1, 32'h05, 32'hDEADBEEF, 1, 0, 32'h05, 0);
      chk("t4_c1_g0", last_g[0], 0);
      chk("t4_c1_g1", last_g[1], 1);
      chk("t4_rvalid", m1_rvalid, 1);
      chk("t4_rdata", m1_rdata, 32'hDEADBEEF);
      cyc(1, 1, 32'h05, 32'hDEADBEEF, 0, 0, 0, 0);
      // both write continuously: grants alternate
      for (int k = 0; k < 4; k++) begin
         t5d = 32'h1000 + k;
         cyc(1, 1, 32'h10, t5d, 1, 1, 32'h11, ~t5d);
         chk("t5_g0", last_g[0], (k % 2) == 0);
         chk("t5_g1", last_g[1], (k % 2) == 1);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic: requests held until granted, occasionally withdrawn
      hr[0] = 0; hr[1] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!hr[i]) begin
               hr[i] = $urandom_range(0, 3) != 0;
               hw[i] = $urandom_range(0, 1) == 1;
               ha[i] = $urandom_range(0, 15);
               hd[i] = $urandom;
            end else if ($urandom_range(0, 9) == 0) hr[i] = 0;
         end
         cyc(hr[0], hw[0], ha[0], hd[0], hr[1], hw[1], ha[1], hd[1]);
         for (int i = 0; i < 2; i++) if (last_g[i]) hr[i] = 0;
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
